// File: rtl/npc_ras_pc.sv
// Registered fetch-PC generator with next-PC select, stall hold,
// exception/eret redirect and a circular return-address stack whose
// predictions are checked against the authoritative jr target.
module npc_ras_pc #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180,
  parameter int               RAS_DEPTH  = 4,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       pc_sel,
  input  logic [WIDTH-1:0] id_pc4,
  input  logic [15:0]      br_offset,
  input  logic [25:0]      j_index,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4,
  output logic             pc_adel,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_miss,
  output logic [CNT_W-1:0] ras_miss_cnt
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(RAS_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  localparam logic [2:0] SEL_SEQ    = 3'b000;
  localparam logic [2:0] SEL_BR     = 3'b001;
  localparam logic [2:0] SEL_J      = 3'b010;
  localparam logic [2:0] SEL_JAL    = 3'b011;
  localparam logic [2:0] SEL_JR     = 3'b100;
  localparam logic [2:0] SEL_JR_RET = 3'b101;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] ras_ptr;
  logic [PTR_W-1:0] ras_ptr_m1;
  logic [PTR_W:0]   ras_count;

  logic [WIDTH-1:0] br_target;
  logic [WIDTH-1:0] j_target;
  logic [WIDTH-1:0] push_val;
  logic [WIDTH-1:0] next_pc;
  logic             push;
  logic             pop;
  logic             miss;

  assign pc4        = pc + WIDTH'(4);
  assign pc_adel    = |pc[1:0];
  assign br_target  = id_pc4 + {{(WIDTH-18){br_offset[15]}}, br_offset, 2'b00};
  assign j_target   = {id_pc4[WIDTH-1:28], j_index, 2'b00};
  assign push_val   = id_pc4 + WIDTH'(4);
  assign ras_ptr_m1 = ras_ptr - PTR_ONE;
  assign ras_empty  = (ras_count == '0);
  assign ras_top    = ras_empty ? '0 : ras_mem[ras_ptr_m1];

  // Next-PC priority select: exception, eret, stall, then pc_sel decode.
  // An empty-stack return is a miss but leaves the stack untouched.
  always_comb begin
    next_pc = pc;
    push    = 1'b0;
    pop     = 1'b0;
    miss    = 1'b0;
    if (exc_req) begin
      next_pc = EXC_VECTOR;
    end else if (eret) begin
      next_pc = epc;
    end else if (!stall) begin
      case (pc_sel)
        SEL_BR:  next_pc = br_target;
        SEL_J:   next_pc = j_target;
        SEL_JAL: begin
          next_pc = j_target;
          push    = 1'b1;
        end
        SEL_JR:  next_pc = jr_target;
        SEL_JR_RET: begin
          next_pc = jr_target;
          if (ras_empty) begin
            miss = 1'b1;
          end else begin
            pop  = 1'b1;
            miss = (ras_top != jr_target);
          end
        end
        default: next_pc = pc4;
      endcase
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= next_pc;
  end

  // Circular return-address stack; a push when full overwrites the oldest.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_ptr   <= '0;
      ras_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (push) begin
      ras_mem[ras_ptr] <= push_val;
      ras_ptr          <= ras_ptr + PTR_ONE;
      if (ras_count != DEPTH_C) ras_count <= ras_count + CNT_ONE;
    end else if (pop) begin
      ras_ptr   <= ras_ptr_m1;
      ras_count <= ras_count - CNT_ONE;
    end
  end

  // Registered miss pulse and saturating miss counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ras_miss     <= 1'b0;
      ras_miss_cnt <= '0;
    end else begin
      ras_miss <= miss;
      if (miss && !(&ras_miss_cnt)) ras_miss_cnt <= ras_miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_npc_ras_pc.sv
// Directed bench for npc_ras_pc: each step drives inputs, queues the
// expected post-edge state, clocks once and compares the queue head.
module tb_npc_ras_pc;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  pc_sel;
  logic [31:0] id_pc4;
  logic [15:0] br_offset;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        pc_adel;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic        ras_miss;
  logic [15:0] ras_miss_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] top;
    logic        empty;
    logic        miss;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  npc_ras_pc dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel),
    .id_pc4(id_pc4), .br_offset(br_offset), .j_index(j_index),
    .jr_target(jr_target), .exc_req(exc_req), .eret(eret), .epc(epc),
    .pc(pc), .pc4(pc4), .pc_adel(pc_adel), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_miss(ras_miss), .ras_miss_cnt(ras_miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field,
                     input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s.%s got=%h expected=%h", tag, field, got, want);
    end
  endtask

  task automatic expect_state(input string tag, input logic [31:0] epc_v,
                              input logic [31:0] top, input logic empty,
                              input logic miss, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.pc = epc_v; e.top = top; e.empty = empty;
    e.miss = miss; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic check_front();
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard_empty got=0 entries expected=1");
      return;
    end
    e = sb.pop_front();
    chk(e.tag, "pc",      pc,                   e.pc);
    chk(e.tag, "pc4",     pc4,                  e.pc + 32'd4);
    chk(e.tag, "pc_adel", {31'd0, pc_adel},     {31'd0, |e.pc[1:0]});
    chk(e.tag, "ras_top", ras_top,              e.top);
    chk(e.tag, "empty",   {31'd0, ras_empty},   {31'd0, e.empty});
    chk(e.tag, "miss",    {31'd0, ras_miss},    {31'd0, e.miss});
    chk(e.tag, "cnt",     {16'd0, ras_miss_cnt}, {16'd0, e.cnt});
  endtask

  task automatic idle_inputs();
    stall = 1'b0; pc_sel = 3'b000; exc_req = 1'b0; eret = 1'b0;
  endtask

  // One accepted clock: queue expectation, clock, compare, return to idle.
  task automatic cycle(input string tag, input logic [31:0] epc_v,
                       input logic [31:0] top, input logic empty,
                       input logic miss, input logic [15:0] cnt);
    expect_state(tag, epc_v, top, empty, miss, cnt);
    @(posedge clk);
    #1;
    check_front();
    idle_inputs();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    id_pc4 = '0; br_offset = '0; j_index = '0; jr_target = '0; epc = '0;
    repeat (2) @(posedge clk);
    #1;
    expect_state("reset", 32'h3000, 32'h0, 1'b1, 1'b0, 16'd0);
    check_front();
    reset = 1'b1;

    cycle("seq1", 32'h3004, 32'h0, 1'b1, 1'b0, 16'd0);
    cycle("seq2", 32'h3008, 32'h0, 1'b1, 1'b0, 16'd0);
    cycle("seq3", 32'h300C, 32'h0, 1'b1, 1'b0, 16'd0);

    pc_sel = 3'b001; id_pc4 = 32'h3010; br_offset = 16'hFFFE;
    cycle("br_back", 32'h3008, 32'h0, 1'b1, 1'b0, 16'd0);
    pc_sel = 3'b001; id_pc4 = 32'h3010; br_offset = 16'h0004;
    cycle("br_fwd", 32'h3020, 32'h0, 1'b1, 1'b0, 16'd0);

    pc_sel = 3'b010; id_pc4 = 32'h3004; j_index = 26'h0000C10;
    cycle("j", 32'h3040, 32'h0, 1'b1, 1'b0, 16'd0);

    pc_sel = 3'b011; id_pc4 = 32'h3004; j_index = 26'h0000C10;
    cycle("jal", 32'h3040, 32'h3008, 1'b0, 1'b0, 16'd0);
    pc_sel = 3'b101; jr_target = 32'h3008;
    cycle("ret_hit", 32'h3008, 32'h0, 1'b1, 1'b0, 16'd0);

    // Five calls into a four-deep stack: the first return address is lost.
    j_index = 26'h0000400;
    pc_sel = 3'b011; id_pc4 = 32'h1000;
    cycle("jal_a", 32'h1000, 32'h1004, 1'b0, 1'b0, 16'd0);
    pc_sel = 3'b011; id_pc4 = 32'h2000;
    cycle("jal_b", 32'h1000, 32'h2004, 1'b0, 1'b0, 16'd0);
    pc_sel = 3'b011; id_pc4 = 32'h5000;
    cycle("jal_c", 32'h1000, 32'h5004, 1'b0, 1'b0, 16'd0);
    pc_sel = 3'b011; id_pc4 = 32'h6000;
    cycle("jal_d", 32'h1000, 32'h6004, 1'b0, 1'b0, 16'd0);
    pc_sel = 3'b011; id_pc4 = 32'h7000;
    cycle("jal_e", 32'h1000, 32'h7004, 1'b0, 1'b0, 16'd0);
    pc_sel = 3'b101; jr_target = 32'h7004;
    cycle("pop_e", 32'h7004, 32'h6004, 1'b0, 1'b0, 16'd0);
    pc_sel = 3'b101; jr_target = 32'h6004;
    cycle("pop_d", 32'h6004, 32'h5004, 1'b0, 1'b0, 16'd0);
    pc_sel = 3'b101; jr_target = 32'h5004;
    cycle("pop_c", 32'h5004, 32'h2004, 1'b0, 1'b0, 16'd0);
    pc_sel = 3'b101; jr_target = 32'h2004;
    cycle("pop_b", 32'h2004, 32'h0, 1'b1, 1'b0, 16'd0);
    pc_sel = 3'b101; jr_target = 32'h2468;
    cycle("pop_empty", 32'h2468, 32'h0, 1'b1, 1'b1, 16'd1);
    cycle("miss_pulse", 32'h246C, 32'h0, 1'b1, 1'b0, 16'd1);

    // Stall holds pc and suppresses the push.
    repeat (3) begin
      stall = 1'b1; pc_sel = 3'b011; id_pc4 = 32'h3000;
      cycle("stall_jal", 32'h246C, 32'h0, 1'b1, 1'b0, 16'd1);
    end
    stall = 1'b1; pc_sel = 3'b011; exc_req = 1'b1;
    cycle("exc_in_stall", 32'h4180, 32'h0, 1'b1, 1'b0, 16'd1);
    eret = 1'b1; epc = 32'h3014;
    cycle("eret", 32'h3014, 32'h0, 1'b1, 1'b0, 16'd1);

    // Wrong-target return still pops the stack.
    pc_sel = 3'b011; id_pc4 = 32'h3018; j_index = 26'h0000C20;
    cycle("jal_f", 32'h3080, 32'h301C, 1'b0, 1'b0, 16'd1);
    pc_sel = 3'b101; jr_target = 32'h3100;
    cycle("ret_wrong", 32'h3100, 32'h0, 1'b1, 1'b1, 16'd2);

    pc_sel = 3'b100; jr_target = 32'h3002;
    cycle("jr_misalign", 32'h3002, 32'h0, 1'b1, 1'b0, 16'd2);
    pc_sel = 3'b111;
    cycle("sel_111_seq", 32'h3006, 32'h0, 1'b1, 1'b0, 16'd2);

    pc_sel = 3'b011; id_pc4 = 32'h3010; j_index = 26'h0000C10;
    cycle("jal_g", 32'h3040, 32'h3014, 1'b0, 1'b0, 16'd2);
    pc_sel = 3'b011; id_pc4 = 32'h3020;
    cycle("jal_h", 32'h3040, 32'h3024, 1'b0, 1'b0, 16'd2);

    // Asynchronous reset mid-cycle, checked before the next clock edge.
    pc_sel = 3'b011; id_pc4 = 32'h3030;
    #3;
    reset = 1'b0;
    #1;
    expect_state("async_reset", 32'h3000, 32'h0, 1'b1, 1'b0, 16'd0);
    check_front();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
